// File: rtl/tx_arb_pkg.sv
// Shared state encoding and default sizing for the UART transmit arbiter.
// Optional watchdog release is enabled with the TX_ARB_TIMEOUT_EN macro.
package tx_arb_pkg;

   localparam int N_REQ_DEFAULT          = 4;
   localparam int TIMEOUT_CYCLES_DEFAULT = 1_000_000;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_START   = 2'd2,
      S_WAIT_TX = 2'd3
   } arb_state_t;

   // Round-robin successor of a lane index, wrapping at n.
   function automatic int nextPtr(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting lane at or after the
// priority pointer, searching upward and wrapping.
module rr_pick
   import tx_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [PTR_W-1:0] i_rr_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [PTR_W-1:0] o_idx,
   output logic             o_any
);

   always_comb begin
      int j;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      j       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(i_rr_ptr) + k) % N_REQ;
         if (!o_any && i_req[j]) begin
            o_grant[j] = 1'b1;
            o_idx      = PTR_W'(j);
            o_any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte-stream requesters.
// Define TX_ARB_TIMEOUT_EN to add a forced release of an idle granted lane.
module tx_arbiter
   import tx_arb_pkg::*;
#(
   parameter int N_REQ          = N_REQ_DEFAULT,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   grant,
   output logic [N_REQ-1:0]   req_ready,
   output logic [7:0]         tx_data,
   output logic               tx_start,
   input  logic               tx_busy,
   output logic               timeout_flag
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
   end

   arb_state_t       r_state;
   logic [N_REQ-1:0] r_grant;
   logic [N_REQ-1:0] r_ready;
   logic [PTR_W-1:0] r_gidx;
   logic [PTR_W-1:0] r_rr;
   logic [7:0]       r_data;
   logic             r_start;
   logic             r_last;

   logic [N_REQ-1:0] w_pick_grant;
   logic [PTR_W-1:0] w_pick_idx;
   logic             w_pick_any;
   logic             w_req_g;
   logic             w_valid_g;
   logic [7:0]       w_lane_data;
   logic             w_timeout;
   logic             w_release;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .i_req    (req),
      .i_rr_ptr (r_rr),
      .o_grant  (w_pick_grant),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   assign w_req_g     = req[r_gidx];
   assign w_valid_g   = req_valid[r_gidx];
   assign w_lane_data = req_data[int'(r_gidx)*8 +: 8];

`ifdef TX_ARB_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TCNT_W-1:0] r_tcnt;
   logic              r_tflag;
   logic              w_armed_idle;

   assign w_armed_idle = (r_state == S_ARMED) && w_req_g && !w_valid_g;
   assign w_timeout    = w_armed_idle && (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

   // Counts consecutive ARMED cycles where the owner has nothing to send.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt  <= '0;
         r_tflag <= 1'b0;
      end else begin
         if (w_armed_idle && !w_timeout)
            r_tcnt <= r_tcnt + 1'b1;
         else
            r_tcnt <= '0;
         if (w_timeout)
            r_tflag <= 1'b1;
      end
   end

   assign timeout_flag = r_tflag;
`else
   assign w_timeout    = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   // A dropped request ends the message after any byte already in flight.
   always_comb begin
      w_release = 1'b0;
      if (r_state == S_ARMED)
         w_release = !w_req_g || w_timeout;
      else if (r_state == S_WAIT_TX)
         w_release = !tx_busy && (r_last || !w_req_g);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_ready <= '0;
         r_gidx  <= '0;
         r_rr    <= '0;
         r_data  <= 8'h00;
         r_start <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_start <= 1'b0;
         if (w_release) begin
            r_grant <= '0;
            r_ready <= '0;
            r_last  <= 1'b0;
            r_rr    <= PTR_W'(nextPtr(int'(r_gidx), N_REQ));
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_pick_any) begin
                     r_grant <= w_pick_grant;
                     r_ready <= w_pick_grant;
                     r_gidx  <= w_pick_idx;
                     r_state <= S_ARMED;
                  end
               end
               S_ARMED: begin
                  if (w_valid_g) begin
                     r_data  <= w_lane_data;
                     r_last  <= req_last[r_gidx];
                     r_ready <= '0;
                     r_start <= 1'b1;
                     r_state <= S_START;
                  end
               end
               S_START: begin
                  if (!w_req_g)
                     r_last <= 1'b1;
                  r_state <= S_WAIT_TX;
               end
               S_WAIT_TX: begin
                  if (!w_req_g)
                     r_last <= 1'b1;
                  if (!tx_busy) begin
                     r_ready <= r_grant;
                     r_state <= S_ARMED;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign grant     = r_grant;
   assign req_ready = r_ready;
   assign tx_data   = r_data;
   assign tx_start  = r_start;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a cycle-by-cycle vector table followed by
// multi-cycle sequences driven against a small uart_tx busy model.
module tb_tx_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [3:0]  grant;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        timeout_flag;

   logic        useModel;
   logic        vecBusy;
   logic [2:0]  busyCnt;
   int          vectors;
   int          miscompares;
   int          startCount;
   logic [7:0]  startData[$];

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [31:0] data;
      logic        busy;
      logic [3:0]  eGrant;
      logic [3:0]  eReady;
      logic        eStart;
      logic [7:0]  eData;
   } vec_t;

   vec_t vecs[$];

   tx_arbiter #(
      .N_REQ          (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .req_data     (req_data),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .grant        (grant),
      .req_ready    (req_ready),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_busy      (tx_busy),
      .timeout_flag (timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // uart_tx stand-in: busy for three cycles starting the cycle after tx_start.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busyCnt <= 3'd0;
      else if (tx_start)
         busyCnt <= 3'd3;
      else if (busyCnt != 3'd0)
         busyCnt <= busyCnt - 3'd1;
   end

   assign tx_busy = useModel ? (busyCnt != 3'd0) : vecBusy;

   always @(negedge clk) begin
      if (rst_n && tx_start) begin
         startCount++;
         startData.push_back(tx_data);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(input logic [3:0] r, input logic [3:0] v, input logic [3:0] l,
                                  input logic [31:0] d, input logic b, input logic [3:0] eg,
                                  input logic [3:0] er, input logic es, input logic [7:0] ed);
      vec_t x;
      x.req = r; x.valid = v; x.last = l; x.data = d; x.busy = b;
      x.eGrant = eg; x.eReady = er; x.eStart = es; x.eData = ed;
      return x;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      req       = v.req;
      req_valid = v.valid;
      req_last  = v.last;
      req_data  = v.data;
      vecBusy   = v.busy;
   endtask

   task automatic resetDut();
      rst_n     = 1'b0;
      req       = '0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      vecBusy   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic waitGrant(input string name, input logic [3:0] exp, input int maxCycles);
      int n = 0;
      while (grant !== exp && n < maxCycles) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput(name, 32'(grant), 32'(exp));
   endtask

   task automatic sendByte(input int lane, input logic [7:0] data, input logic last);
      int n = 0;
      while (!req_ready[lane] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready[lane]) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL ready_wait lane%0d: actual req_ready=%b required bit %0d set", lane, req_ready, lane);
      end
      req_valid[lane]          = 1'b1;
      req_last[lane]           = last;
      req_data[8*lane +: 8]    = data;
      @(posedge clk); #1;
      req_valid[lane] = 1'b0;
      req_last[lane]  = 1'b0;
   endtask

   initial begin
      int base;
      int held;
      logic [3:0] expG;
      vectors     = 0;
      miscompares = 0;
      startCount  = 0;
      useModel    = 1'b0;

      // Reset values must appear while rst_n is low, before any clock edge.
      rst_n = 1'b0; req = '0; req_valid = '0; req_last = '0; req_data = '0; vecBusy = 1'b0;
      #1;
      checkOutput("rst_grant", 32'(grant), 32'h0);
      checkOutput("rst_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_start", 32'(tx_start), 32'h0);
      checkOutput("rst_data", 32'(tx_data), 32'h0);
      checkOutput("rst_flag", 32'(timeout_flag), 32'h0);
      resetDut();

      //                req   valid last  data          busy  grant ready start data
      vecs.push_back(mkVec(4'h1, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h1, 4'h1, 1'b0, 8'h00));
      vecs.push_back(mkVec(4'h1, 4'h1, 4'h0, 32'h00000048, 1'b0, 4'h1, 4'h0, 1'b1, 8'h48));
      vecs.push_back(mkVec(4'h1, 4'h0, 4'h0, 32'h00000000, 1'b1, 4'h1, 4'h0, 1'b0, 8'h48));
      vecs.push_back(mkVec(4'h1, 4'h0, 4'h0, 32'h00000000, 1'b1, 4'h1, 4'h0, 1'b0, 8'h48));
      vecs.push_back(mkVec(4'h1, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h1, 4'h1, 1'b0, 8'h48));
      vecs.push_back(mkVec(4'h1, 4'h1, 4'h0, 32'h00000069, 1'b0, 4'h1, 4'h0, 1'b1, 8'h69));
      vecs.push_back(mkVec(4'h1, 4'h0, 4'h0, 32'h00000000, 1'b1, 4'h1, 4'h0, 1'b0, 8'h69));
      vecs.push_back(mkVec(4'h1, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h1, 4'h1, 1'b0, 8'h69));
      vecs.push_back(mkVec(4'h1, 4'h1, 4'h1, 32'h0000000A, 1'b0, 4'h1, 4'h0, 1'b1, 8'h0A));
      vecs.push_back(mkVec(4'h1, 4'h0, 4'h0, 32'h00000000, 1'b1, 4'h1, 4'h0, 1'b0, 8'h0A));
      vecs.push_back(mkVec(4'h1, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h0A));
      vecs.push_back(mkVec(4'h5, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h4, 4'h4, 1'b0, 8'h0A));
      vecs.push_back(mkVec(4'h5, 4'h1, 4'h1, 32'h00000055, 1'b0, 4'h4, 4'h4, 1'b0, 8'h0A));
      vecs.push_back(mkVec(4'h5, 4'h4, 4'h4, 32'h00330000, 1'b0, 4'h4, 4'h0, 1'b1, 8'h33));
      vecs.push_back(mkVec(4'h5, 4'h0, 4'h0, 32'h00000000, 1'b1, 4'h4, 4'h0, 1'b0, 8'h33));
      vecs.push_back(mkVec(4'h5, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h33));
      vecs.push_back(mkVec(4'h5, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h1, 4'h1, 1'b0, 8'h33));
      vecs.push_back(mkVec(4'h4, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h33));
      vecs.push_back(mkVec(4'h4, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h4, 4'h4, 1'b0, 8'h33));
      vecs.push_back(mkVec(4'h4, 4'h4, 4'h0, 32'h00770000, 1'b0, 4'h4, 4'h0, 1'b1, 8'h77));
      vecs.push_back(mkVec(4'h0, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h4, 4'h0, 1'b0, 8'h77));
      vecs.push_back(mkVec(4'h0, 4'h0, 4'h0, 32'h00000000, 1'b1, 4'h4, 4'h0, 1'b0, 8'h77));
      vecs.push_back(mkVec(4'h0, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h77));
      vecs.push_back(mkVec(4'h0, 4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h77));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk); #1;
         vectors++;
         if (grant !== vecs[i].eGrant || req_ready !== vecs[i].eReady ||
             tx_start !== vecs[i].eStart || tx_data !== vecs[i].eData) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: actual grant=%b ready=%b start=%b data=%h required grant=%b ready=%b start=%b data=%h",
                     i, grant, req_ready, tx_start, tx_data,
                     vecs[i].eGrant, vecs[i].eReady, vecs[i].eStart, vecs[i].eData);
         end
      end

      // Simultaneous requests after reset: rr_ptr=0 favours lane 0, then lane 2.
      useModel = 1'b1;
      resetDut();
      req = 4'b0101;
      @(posedge clk); #1;
      checkOutput("tie_first_grant", 32'(grant), 32'h1);
      sendByte(0, 8'h11, 1'b1);
      waitGrant("tie_release0", 4'b0000, 20);
      waitGrant("tie_second_grant", 4'b0100, 5);
      sendByte(2, 8'h22, 1'b1);
      req = 4'b0000;
      waitGrant("tie_release2", 4'b0000, 20);

      // Two persistent requesters alternate on single-byte messages.
      resetDut();
      startData.delete();
      base = startCount;
      req  = 4'b1010;
      for (int m = 0; m < 8; m++) begin
         expG = (m % 2 == 0) ? 4'b0010 : 4'b1000;
         waitGrant($sformatf("alt_grant%0d", m), expG, 10);
         sendByte((m % 2 == 0) ? 1 : 3, 8'h30 + 8'(m), 1'b1);
         waitGrant($sformatf("alt_release%0d", m), 4'b0000, 20);
      end
      req = 4'b0000;
      checkOutput("alt_start_count", 32'(startCount - base), 32'd8);
      for (int m = 0; m < 8 && m < startData.size(); m++)
         checkOutput($sformatf("alt_byte%0d", m), 32'(startData[m]), 32'h30 + 32'(m));

      // Asynchronous reset while waiting on uart_tx.
      resetDut();
      req = 4'b0001;
      waitGrant("rstmid_grant", 4'b0001, 5);
      sendByte(0, 8'hA5, 1'b0);
      @(posedge clk); #1;
      checkOutput("rstmid_busy_seen", 32'(tx_busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rstmid_grant0", 32'(grant), 32'h0);
      checkOutput("rstmid_ready0", 32'(req_ready), 32'h0);
      checkOutput("rstmid_start0", 32'(tx_start), 32'h0);
      checkOutput("rstmid_data0", 32'(tx_data), 32'h0);
      base = startCount;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("rstmid_no_start", 32'(startCount - base), 32'd0);
      checkOutput("rstmid_regrant", 32'(grant), 32'h1);

      // Granted lane that never presents data.
      resetDut();
      req = 4'b0001;
      waitGrant("idle_owner_grant", 4'b0001, 5);
`ifdef TX_ARB_TIMEOUT_EN
      held = 0;
      while (grant != 4'b0000 && held < 100) begin
         @(posedge clk); #1;
         held++;
      end
      checkOutput("timeout_cycles", 32'(held), 32'd16);
      checkOutput("timeout_flag_set", 32'(timeout_flag), 32'h1);
`else
      held = 0;
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk); #1;
         if (grant === 4'b0001) held++;
      end
      checkOutput("hold_cycles", 32'(held), 32'd1000);
      checkOutput("hold_flag_clear", 32'(timeout_flag), 32'h0);
`endif
      req = 4'b0000;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
